wptr_ctrl: RTL and testbench
============================

WPTR_CTRL -- requirements
Module: wptr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning FIFO depth 2^ADDR_WIDTH; legal range >= 2.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of read-pointer synchronizer flops; legal range >= 2.
REQ-003 wclk  input  1  write clock; all state SHALL update on the rising edge.
REQ-004 wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 rptr  input  ADDR_WIDTH+1  Gray-coded read pointer from the read clock domain, unsynchronized.
REQ-006 winc  input  1  write request.
REQ-007 wafull_thresh  input  ADDR_WIDTH+1  almost-full threshold in entries, quasi-static.
REQ-008 wovf_clr  input  1  clears sticky overflow.
REQ-009 wack  output  1  write accepted this cycle (combinational).
REQ-010 waddr  output  ADDR_WIDTH  binary memory write address.
REQ-011 wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to the read domain.
REQ-012 wfull  output  1  registered full flag.
REQ-013 wafull  output  1  registered almost-full flag.
REQ-014 wlevel  output  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
REQ-015 woverflow  output  1  sticky write-while-full flag.

Function
REQ-016 The block SHALL synchronize rptr through a SYNC_STAGES-deep flop chain on wclk; the last stage output is wq_rptr.
REQ-017 The block SHALL drive wack = winc & ~wfull.
REQ-018 The block SHALL compute wbinnext = wbin + wack, modulo 2^(ADDR_WIDTH+1), and wgraynext = (wbinnext >> 1) ^ wbinnext.
REQ-019 On each edge, the block SHALL load wbin <= wbinnext and wptr <= wgraynext, and SHALL drive waddr = wbin[ADDR_WIDTH-1:0], so the address wraps 2^ADDR_WIDTH-1 -> 0.
REQ-020 The block SHALL register wfull <= (wgraynext == {~wq_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq_rptr[ADDR_WIDTH-2:0]}).
REQ-021 The block SHALL convert wq_rptr to binary rbin_s by Gray-to-binary XOR prefix.
REQ-022 The block SHALL register wlevel <= (wbinnext - rbin_s) modulo 2^(ADDR_WIDTH+1).
REQ-023 The block SHALL register wafull <= (level_next >= wafull_thresh), where level_next is the value being loaded into wlevel; a threshold of 0 SHALL hold wafull at 1 after reset.
REQ-024 The block SHALL set woverflow on an edge where winc & wfull; otherwise wovf_clr SHALL clear it; if set and clear coincide, set SHALL win.
REQ-025 While wfull=1, wbin, wptr and waddr SHALL hold; the write SHALL be dropped and not retried.
REQ-026 An rptr change SHALL become visible in wfull, wlevel and wafull on the (SYNC_STAGES+1)th rising edge after it is sampled.
REQ-027 Simultaneous write and read-pointer advance SHALL be handled combinationally in the same next-state computation, with no priority conflict.
REQ-028 wfull and wlevel SHALL be conservative: a stale wq_rptr SHALL only overstate the fill, never understate it.

Reset
REQ-029 On wrst_n=0, the block SHALL asynchronously clear wbin, wptr, all synchronizer stages, wfull, wlevel and woverflow to 0, and SHALL set wafull to (wafull_thresh == 0).
REQ-030 Reset asserted mid-operation SHALL discard all state immediately; the first post-reset write SHALL go to waddr 0.
REQ-031 The block SHALL require reset deassertion synchronous to wclk externally.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, wafull_thresh=6)
REQ-032 Reset, then check idle: waddr=0, wptr=0000, wfull=0, wafull=0, wlevel=0, woverflow=0.
REQ-033 rptr=0000, winc=1 for 8 edges: waddr steps 0..7 and wraps; after the 6th edge wafull=1 and wlevel=6; after the 8th edge wfull=1, wlevel=8, wptr=1100, waddr=0.
REQ-034 In the full state, winc=1 for 1 edge: wack=0, pointers hold, woverflow=1; then wovf_clr=1 for 1 edge: woverflow=0.
REQ-035 From full, rptr set to 0010 (gray 3): on the 3rd edge wfull=0, wlevel=5, wafull=0; next write gives wack=1 and waddr 0 -> 1.
REQ-036 Same edge winc=1 and wovf_clr=1 with wfull=1: woverflow stays 1.
REQ-037 Assert wrst_n=0 mid-write burst with wlevel=4: all outputs clear immediately without a clock edge; after release, the first accepted write uses waddr=0.

Source files
------------

// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO: Gray write pointer,
// read-pointer synchronizer, full/almost-full/level flags and sticky overflow.
module wptr_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [ADDR_WIDTH:0]   rptr,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wafull_thresh,
  input  logic                  wovf_clr,
  output logic                  wack,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  wq_rptr;
  logic [PW-1:0]                  rbin_s;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;

  // NOTE: synchronizer flops are reset like every other flop so a stale read
  // pointer from before reset can never leak into the post-reset level.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(wq_rptr >> i);
    end
  end

  // Write and read advance meet in one subtraction, so there is no priority.
  assign wack     = winc & ~wfull_q;
  assign wbin_d   = wbin_q + PW'(wack);
  assign wptr_d   = (wbin_d >> 1) ^ wbin_d;
  assign wfull_d  = (wptr_d == {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]});
  assign wlevel_d = wbin_d - rbin_s;
  assign wafull_d = (wlevel_d >= wafull_thresh);
  assign wovf_d   = (winc & wfull_q) ? 1'b1 : (wovf_clr ? 1'b0 : wovf_q);

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= (wafull_thresh == '0);
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign wptr      = wptr_q;
  assign wfull     = wfull_q;
  assign wafull    = wafull_q;
  assign wlevel    = wlevel_q;
  assign woverflow = wovf_q;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl: directed scenarios plus a randomized
// writer/reader run, compared against a count-based FIFO model.
module tb_wptr_ctrl;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 1 << (AW + 1);

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic [AW:0]   rptr;
  logic          winc;
  logic [AW:0]   wafull_thresh;
  logic          wovf_clr;
  logic          wack;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wlevel;
  logic          woverflow;

  wptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .rptr          (rptr),
    .winc          (winc),
    .wafull_thresh (wafull_thresh),
    .wovf_clr      (wovf_clr),
    .wack          (wack),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .wafull        (wafull),
    .wlevel        (wlevel),
    .woverflow     (woverflow)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: total writes and reads as counts modulo 2*DEPTH; the writer sees
  // the read count only after it has travelled through SS sampling edges.
  int m_wcnt;
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;
  int rd_cnt;
  int seen_rd[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    return (AW+1)'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_afull = (wafull_thresh == 0);
    m_ovf   = 1'b0;
    seen_rd = {};
    repeat (SS) seen_rd.push_back(0);
  endtask

  task automatic model_edge();
    int synced;
    bit accepted;
    accepted = winc && !m_full;
    synced   = seen_rd.pop_front();
    seen_rd.push_back(rd_cnt);
    if (winc && m_full) m_ovf = 1'b1;
    else if (wovf_clr)  m_ovf = 1'b0;
    m_wcnt  = (m_wcnt + int'(accepted)) % MOD;
    m_level = (m_wcnt - synced + MOD) % MOD;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= int'(wafull_thresh));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".waddr"},     waddr,     m_wcnt % DEPTH);
    check({tag, ".wptr"},      wptr,      to_gray(m_wcnt));
    check({tag, ".wfull"},     wfull,     m_full);
    check({tag, ".wafull"},    wafull,    m_afull);
    check({tag, ".wlevel"},    wlevel,    m_level);
    check({tag, ".woverflow"}, woverflow, m_ovf);
  endtask

  // One clock: drive inputs, check the combinational ack, clock, check state.
  task automatic step(input bit inc, input bit clr);
    winc     = inc;
    wovf_clr = clr;
    rptr     = to_gray(rd_cnt);
    #1;
    check("wack", wack, inc && !m_full);
    @(posedge wclk);
    model_edge();
    #1;
    check_outputs("step");
  endtask

  task automatic release_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
  endtask

  initial begin
    wrst_n        = 1'b0;
    winc          = 1'b0;
    wovf_clr      = 1'b0;
    wafull_thresh = 6;
    rd_cnt        = 0;
    rptr          = '0;
    #2;
    model_reset();
    check_outputs("reset");
    #10;
    release_reset();
    check_outputs("idle");

    // Fill from empty: address walks 0..7 and wraps, flags at 6 and 8.
    for (int k = 1; k <= DEPTH; k++) begin
      check("fill.waddr_pre", waddr, k - 1);
      step(1'b1, 1'b0);
      if (k == 6) begin
        check("fill6.wlevel", wlevel, 6);
        check("fill6.wafull", wafull, 1);
      end
    end
    check("full.wfull",  wfull,  1);
    check("full.wlevel", wlevel, 8);
    check("full.wptr",   wptr,   4'b1100);
    check("full.waddr",  waddr,  0);

    // Write while full is dropped and flagged; clear drops the flag.
    step(1'b1, 1'b0);
    check("ovf.set",   woverflow, 1);
    check("ovf.waddr", waddr,     0);
    check("ovf.wptr",  wptr,      4'b1100);
    step(1'b0, 1'b1);
    check("ovf.clr", woverflow, 0);

    // Set and clear on the same edge: set wins.
    step(1'b1, 1'b1);
    check("ovf.set_wins", woverflow, 1);
    step(1'b0, 1'b1);
    check("ovf.clr2", woverflow, 0);

    // Reader consumes three entries; visible on the third edge.
    rd_cnt = 3;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rd.wfull_edge2", wfull, 1);
    step(1'b0, 1'b0);
    check("rd.wfull",  wfull,  0);
    check("rd.wlevel", wlevel, 5);
    check("rd.wafull", wafull, 0);
    check("rd.waddr_pre", waddr, 0);
    step(1'b1, 1'b0);
    check("rd.waddr_post", waddr, 1);

    // Randomized writer and reader; reader speed changes to reach both ends.
    for (int i = 0; i < 600; i++) begin
      int rd_pct;
      rd_pct = (i < 300) ? 25 : 75;
      if (((m_wcnt - rd_cnt + MOD) % MOD) > 0 && $urandom_range(0, 99) < rd_pct)
        rd_cnt = (rd_cnt + 1) % MOD;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Reset in the middle of a write burst at level 4.
    rd_cnt = 0;
    wrst_n = 1'b0;
    #1;
    model_reset();
    release_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    check("mid.wlevel", wlevel, 4);
    winc = 1'b1;
    #2;
    wrst_n = 1'b0;
    #1;
    model_reset();
    check("mid.waddr",     waddr,     0);
    check("mid.wptr",      wptr,      0);
    check("mid.wlevel",    wlevel,    0);
    check("mid.wfull",     wfull,     0);
    check("mid.wafull",    wafull,    0);
    check("mid.woverflow", woverflow, 0);
    release_reset();
    check("mid.first_waddr", waddr, 0);
    step(1'b1, 1'b0);
    check("mid.next_waddr", waddr, 1);

    // Zero threshold: almost-full asserted straight out of reset.
    step(1'b0, 1'b0);
    wafull_thresh = 0;
    rd_cnt        = 0;
    wrst_n        = 1'b0;
    #1;
    model_reset();
    check("thr0.reset_wafull", wafull, 1);
    release_reset();
    step(1'b0, 1'b0);
    check("thr0.idle_wafull", wafull, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
